// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : divider_pkg
// Description : Shared definitions for the restoring divider: state encoding
//               constants and the FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package divider_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] S_SHIFT = 3'd1;
  localparam logic [STATE_W-1:0] S_SUB   = 3'd2;
  localparam logic [STATE_W-1:0] S_FIX   = 3'd3;
  localparam logic [STATE_W-1:0] S_DONE  = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = S_IDLE,
    ST_SHIFT = S_SHIFT,
    ST_SUB   = S_SUB,
    ST_FIX   = S_FIX,
    ST_DONE  = S_DONE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/div_sub_stage.sv
`default_nettype none
// ============================================================================
// Module      : div_sub_stage
// Description : Combinational WIDTH+1-bit trial subtraction A - {0,M}.
//               o_ge is high when A >= M (difference is non-negative).
// Ports       : i_a    [WIDTH:0]   partial remainder
//               i_m    [WIDTH-1:0] divisor
//               o_diff [WIDTH:0]   A - {0,M}
//               o_ge   1           A >= M
// Revision    : 1.0 - initial release
// ============================================================================
module div_sub_stage #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH:0]   o_diff,
  output logic             o_ge
);

  assign o_diff = i_a - {1'b0, i_m};
  // A never exceeds 2M-1, so the MSB of the wrapped difference is a valid sign.
  assign o_ge   = ~o_diff[WIDTH];

endmodule
`default_nettype wire

// File: rtl/restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : restoring_divider
// Description : Sequential restoring (shift-and-subtract) integer divider.
//               One quotient bit per two clocks (SHIFT then SUB).
//               Optional macro SIGNED_DIV_EN: two's complement operands,
//               magnitude division plus a one-cycle sign FIX state.
// Ports       : clk          rising-edge clock
//               reset        asynchronous active-low reset
//               start        request, sampled when not busy
//               dividend     numerator   [WIDTH-1:0]
//               divisor      denominator [WIDTH-1:0]
//               quotient     registered result [WIDTH-1:0]
//               remainder    registered result [WIDTH-1:0]
//               busy         high while iterating
//               o_ready      high in DONE, results valid
//               div_by_zero  high in DONE when the divisor was zero
// Revision    : 1.0 - initial release
// ============================================================================
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             o_ready,
  output logic             div_by_zero
);

  import divider_pkg::*;

  localparam int              CNT_W      = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [CNT_W-1:0] r_count;

  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH:0]   w_a_next;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_dd_load;
  logic [WIDTH-1:0] w_dv_load;

`ifdef SIGNED_DIV_EN
  logic r_sq;
  logic r_sr;
  // Division runs on magnitudes; -2^(WIDTH-1) maps onto itself, which is the
  // correct unsigned magnitude.
  assign w_dd_load = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
  assign w_dv_load = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;
`else
  assign w_dd_load = dividend;
  assign w_dv_load = divisor;
`endif

  div_sub_stage #(
    .WIDTH (WIDTH)
  ) u_sub (
    .i_a    (r_a),
    .i_m    (r_m),
    .o_diff (w_diff),
    .o_ge   (w_ge)
  );

  // Restore A when the trial subtraction goes negative.
  assign w_a_next = w_ge ? w_diff : r_a;
  assign w_q_next = {r_q[WIDTH-1:1], w_ge};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_q         <= '0;
      r_m         <= '0;
      r_count     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      o_ready     <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
      r_sq        <= 1'b0;
      r_sr        <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            o_ready     <= 1'b0;
            div_by_zero <= 1'b0;
            r_a         <= '0;
            r_q         <= w_dd_load;
            r_m         <= w_dv_load;
            r_count     <= C_CNT_INIT;
`ifdef SIGNED_DIV_EN
            r_sq        <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_sr        <= dividend[WIDTH-1];
`endif
            if (divisor == '0) begin
              // Raw dividend goes to remainder, even in the signed build.
              r_state     <= ST_DONE;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              o_ready     <= 1'b1;
            end else begin
              r_state <= ST_SHIFT;
              busy    <= 1'b1;
            end
          end
        end

        ST_SHIFT: begin
          {r_a, r_q} <= {r_a[WIDTH-1:0], r_q, 1'b0};
          r_state    <= ST_SUB;
        end

        ST_SUB: begin
          r_a     <= w_a_next;
          r_q     <= w_q_next;
          r_count <= r_count - C_CNT_ONE;
          if (r_count == C_CNT_ONE) begin
            quotient  <= w_q_next;
            remainder <= w_a_next[WIDTH-1:0];
`ifdef SIGNED_DIV_EN
            r_state   <= ST_FIX;
`else
            r_state   <= ST_DONE;
            busy      <= 1'b0;
            o_ready   <= 1'b1;
`endif
          end else begin
            r_state <= ST_SHIFT;
          end
        end

`ifdef SIGNED_DIV_EN
        ST_FIX: begin
          if (r_sq) quotient  <= ~quotient  + WIDTH'(1);
          if (r_sr) remainder <= ~remainder + WIDTH'(1);
          r_state <= ST_DONE;
          busy    <= 1'b0;
          o_ready <= 1'b1;
        end
`endif

        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_restoring_divider
// Description : Directed, table-driven bench for restoring_divider plus hand
//               sequences for ignored start, mid-run reset and back-to-back
//               operation. Follows SIGNED_DIV_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_restoring_divider;

  localparam int W = 8;
`ifdef SIGNED_DIV_EN
  localparam int LAT = 2 * W + 1;
`else
  localparam int LAT = 2 * W;
`endif
  localparam int NV = 8;

  typedef struct {
    logic [W-1:0] dd;
    logic [W-1:0] dv;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         o_ready;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;

  vec_t vecs [NV];

  restoring_divider #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .o_ready     (o_ready),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Pulse start for one edge; returns at the negedge following the accept edge.
  task automatic do_start(input logic [W-1:0] dd, input logic [W-1:0] dv);
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Counts negedge samples until o_ready, and how many of them saw busy.
  task automatic wait_ready(input string name, output int n, output int bc);
    n  = 0;
    bc = 0;
    while (!o_ready && n < 100) begin
      if (busy) bc++;
      @(negedge clk);
      n++;
    end
    if (n >= 100) check({name, "_timeout"}, 32'(n), 32'(LAT));
  endtask

  initial begin
    int n;
    int bc;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;

`ifdef SIGNED_DIV_EN
    vecs[0] = '{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0};  // -100 / 7
    vecs[1] = '{8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0};  // 100 / -7
    vecs[2] = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0};  // -128 / -1 wraps
    vecs[3] = '{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0};  // 100 / 7
    vecs[4] = '{8'hF9, 8'h00, 8'hFF, 8'hF9, 1'b1};  // -7 / 0
    vecs[5] = '{8'h05, 8'h09, 8'h00, 8'h05, 1'b0};  // 5 / 9
    vecs[6] = '{8'h00, 8'hFB, 8'h00, 8'h00, 1'b0};  // 0 / -5
    vecs[7] = '{8'h7F, 8'h02, 8'h3F, 8'h01, 1'b0};  // 127 / 2
`else
    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0};
    vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0};
    vecs[3] = '{8'd9,   8'd9,   8'd1,   8'd0,  1'b0};
    vecs[4] = '{8'd42,  8'd0,   8'hFF,  8'd42, 1'b1};
    vecs[5] = '{8'd0,   8'd5,   8'd0,   8'd0,  1'b0};
    vecs[6] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0};
    vecs[7] = '{8'd254, 8'd16,  8'd15,  8'd14, 1'b0};
`endif

    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("rst_q",     32'(quotient),    32'd0);
    check("rst_r",     32'(remainder),   32'd0);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_ready", 32'(o_ready),     32'd0);
    check("rst_dbz",   32'(div_by_zero), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      do_start(vecs[i].dd, vecs[i].dv);
      wait_ready($sformatf("v%0d", i), n, bc);
      check($sformatf("v%0d_lat", i),   32'(n),           32'(vecs[i].dbz ? 0 : LAT));
      check($sformatf("v%0d_busyn", i), 32'(bc),          32'(vecs[i].dbz ? 0 : LAT));
      check($sformatf("v%0d_q", i),     32'(quotient),    32'(vecs[i].q));
      check($sformatf("v%0d_r", i),     32'(remainder),   32'(vecs[i].r));
      check($sformatf("v%0d_dbz", i),   32'(div_by_zero), 32'(vecs[i].dbz));
      check($sformatf("v%0d_busy", i),  32'(busy),        32'd0);
      @(negedge clk);
      check($sformatf("v%0d_hold_rdy", i), 32'(o_ready),  32'd1);
      check($sformatf("v%0d_hold_q", i),   32'(quotient), 32'(vecs[i].q));
    end

    // Start pulse while busy is ignored
    do_start(8'd100, 8'd7);
    repeat (4) @(negedge clk);
    dividend = 8'd200;
    divisor  = 8'd3;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    check("ign_busy", 32'(busy), 32'd1);
    wait_ready("ign", n, bc);
    check("ign_lat", 32'(n + 5),   32'(LAT));
    check("ign_q",   32'(quotient),  32'd14);
    check("ign_r",   32'(remainder), 32'd2);

    // Reset in the middle of a division
    do_start(8'd100, 8'd7);
    repeat (7) @(negedge clk);
    reset = 1'b0;
    #1;
    check("mrst_q",     32'(quotient),    32'd0);
    check("mrst_r",     32'(remainder),   32'd0);
    check("mrst_busy",  32'(busy),        32'd0);
    check("mrst_ready", 32'(o_ready),     32'd0);
    check("mrst_dbz",   32'(div_by_zero), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy",  32'(busy),    32'd0);
    check("idle_ready", 32'(o_ready), 32'd0);
`ifdef SIGNED_DIV_EN
    exp_q = 8'hEE;  // 0xC8 = -56; -56/3 = -18 r -2
    exp_r = 8'hFE;
`else
    exp_q = 8'd66;
    exp_r = 8'd2;
`endif
    do_start(8'd200, 8'd3);
    wait_ready("post", n, bc);
    check("post_lat", 32'(n),         32'(LAT));
    check("post_q",   32'(quotient),  32'(exp_q));
    check("post_r",   32'(remainder), 32'(exp_r));

    // start held high: back-to-back divisions
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(negedge clk);
    wait_ready("b2b0", n, bc);
    check("b2b0_lat", 32'(n),         32'(LAT));
    check("b2b0_q",   32'(quotient),  32'd14);
    check("b2b0_r",   32'(remainder), 32'd2);
    dividend = 8'd50;
    divisor  = 8'd5;
    @(negedge clk);
    check("b2b_pulse_rdy",  32'(o_ready), 32'd0);
    check("b2b_pulse_busy", 32'(busy),    32'd1);
    wait_ready("b2b1", n, bc);
    start = 1'b0;
    check("b2b1_lat", 32'(n),         32'(LAT));
    check("b2b1_q",   32'(quotient),  32'd10);
    check("b2b1_r",   32'(remainder), 32'd0);
    @(negedge clk);
    check("b2b1_hold", 32'(o_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
